// File: rtl/bkg_collision_query_pkg.sv
// Shared definitions for the background collision query: map geometry,
// sprite box size, bus widths, FSM and corner encodings, tile helper.
package bkg_collision_query_pkg;

    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;
    localparam int TILE_SHIFT = 5;
    localparam int SPR_W      = 32;
    localparam int SPR_H      = 32;
    localparam int ADDR_W     = 9;
    localparam int TILE_W     = 3;
    localparam int POS_W      = 10;
    localparam int CRD_W      = 11;

    localparam logic [TILE_W-1:0] TILE_FLOOR = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CRN_TL = 2'd0,
        CRN_TR = 2'd1,
        CRN_BL = 2'd2,
        CRN_BR = 2'd3
    } corner_e;

    // A corner blocks the sprite if it lies off the map or on any non-floor tile.
    function automatic logic tile_blocks(input logic [TILE_W-1:0] code, input logic oob);
        return oob | (code != TILE_FLOOR);
    endfunction

endpackage

// File: rtl/bkg_collision_query_tile_addr.sv
// Pixel coordinate -> tile-map ROM address, with off-map detection.
// Purely combinational; row*20 is built from two shifts to avoid a multiplier.
module bkg_collision_query_tile_addr
    import bkg_collision_query_pkg::*;
(
    input  logic [CRD_W-1:0]  cx_i,
    input  logic [CRD_W-1:0]  cy_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oob_o
);

    localparam int TC_W = CRD_W - TILE_SHIFT;

    logic [TC_W-1:0]   col_s;
    logic [TC_W-1:0]   row_s;
    logic [ADDR_W-1:0] col9_s;
    logic [ADDR_W-1:0] row9_s;

    assign col_s  = TC_W'(cx_i >> TILE_SHIFT);
    assign row_s  = TC_W'(cy_i >> TILE_SHIFT);
    assign col9_s = ADDR_W'(col_s);
    assign row9_s = ADDR_W'(row_s);

    // Bounds check, then linear address row*20+col; off-map corners read address 0.
    always_comb begin
        oob_o = (col_s >= TC_W'(MAP_W)) || (row_s >= TC_W'(MAP_H));
        if (oob_o) begin
            addr_o = {ADDR_W{1'b0}};
        end else begin
            addr_o = (row9_s << 4) + (row9_s << 2) + col9_s;
        end
    end

endmodule

// File: rtl/bkg_collision_query.sv
// Background collision query: walks the four bounding-box corners of a sprite
// through the tile-map ROM and reports whether any corner is blocked.
// Optional build macro BKG_CQ_EARLY_EXIT_EN: finish on the first blocked or
// off-map corner instead of always walking all four.
module bkg_collision_query
    import bkg_collision_query_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TILE_W-1:0] rom_q,
    output logic              busy,
    output logic              done,
    output logic              blocked
);

`ifdef BKG_CQ_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    localparam logic [CRD_W-1:0] SPR_DX = CRD_W'(SPR_W - 1);
    localparam logic [CRD_W-1:0] SPR_DY = CRD_W'(SPR_H - 1);

    state_e           state_q;
    corner_e          idx_q;
    logic [POS_W-1:0] pos_x_q;
    logic [POS_W-1:0] pos_y_q;
    logic             acc_q;
    logic             acc_d;
    logic             busy_q;
    logic             done_q;
    logic             blocked_q;

    logic [CRD_W-1:0]  cx_s;
    logic [CRD_W-1:0]  cy_s;
    logic [ADDR_W-1:0] addr_s;
    logic              oob_s;
    logic              hit_s;
    logic              last_s;

    // Corner mux: offset the latched top-left by the sprite extent, 11-bit so no wrap.
    always_comb begin
        cx_s = {1'b0, pos_x_q};
        cy_s = {1'b0, pos_y_q};
        if ((idx_q == CRN_TR) || (idx_q == CRN_BR)) begin
            cx_s = {1'b0, pos_x_q} + SPR_DX;
        end else begin
            cx_s = {1'b0, pos_x_q};
        end
        if ((idx_q == CRN_BL) || (idx_q == CRN_BR)) begin
            cy_s = {1'b0, pos_y_q} + SPR_DY;
        end else begin
            cy_s = {1'b0, pos_y_q};
        end
    end

    bkg_collision_query_tile_addr u_tile_addr (
        .cx_i   (cx_s),
        .cy_i   (cy_s),
        .addr_o (addr_s),
        .oob_o  (oob_s)
    );

    // ROM is only addressed for in-bounds corners while walking; otherwise parked at 0.
    always_comb begin
        if ((state_q == ST_CHECK) && !oob_s) begin
            rom_addr = addr_s;
        end else begin
            rom_addr = {ADDR_W{1'b0}};
        end
    end

    // Current corner verdict, running result, and whether this is the final corner.
    always_comb begin
        hit_s  = tile_blocks(rom_q, oob_s);
        acc_d  = acc_q | hit_s;
        last_s = (idx_q == CRN_BR) || (EARLY_EXIT && hit_s);
    end

    // Query FSM: latch position on request, walk corners, publish the result for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= CRN_TL;
            pos_x_q   <= {POS_W{1'b0}};
            pos_y_q   <= {POS_W{1'b0}};
            acc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        pos_x_q <= pos_x;
                        pos_y_q <= pos_y;
                        acc_q   <= 1'b0;
                        idx_q   <= CRN_TL;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    acc_q <= acc_d;
                    if (last_s) begin
                        blocked_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        idx_q   <= corner_e'(idx_q + 2'd1);
                        state_q <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= CRN_TL;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= CRN_TL;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign blocked = blocked_q;

endmodule
